// File: rtl/johnson_checker_pkg.sv
// ============================================================================
// johnson_checker_pkg : FSM state encodings and Johnson-code helper functions
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package johnson_checker_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Bits needed to index the 2*width states of a width-bit Johnson sequence.
  function automatic int phase_bits(input int width);
    return (2 * width > 1) ? $clog2(2 * width) : 1;
  endfunction

  // Canonical Johnson word for phase k (width is at most 63).
  function automatic logic [63:0] johnson_pattern(input int width, input int k);
    logic [63:0] ones;
    ones = (64'd1 << width) - 64'd1;
    if (k <= width) begin
      return (64'd1 << k) - 64'd1;
    end
    return ones & ~((64'd1 << (k - width)) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_decode.sv
// ============================================================================
// johnson_decode : combinational map from a Johnson word to {legal, phase}
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_decode
  import johnson_checker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             count,
  output logic                         is_legal,
  output logic [phase_bits(WIDTH)-1:0] phase_idx
);

  localparam int PW = phase_bits(WIDTH);

  logic [2*WIDTH-1:0] w_match;

  for (genvar k = 0; k < 2 * WIDTH; k++) begin : g_phase
    localparam logic [WIDTH-1:0] PAT = WIDTH'(johnson_pattern(WIDTH, k));
    assign w_match[k] = (count == PAT);
  end

  // Legal words are one-hot in w_match, so OR-ing the indices encodes them.
  always_comb begin
    is_legal  = |w_match;
    phase_idx = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (w_match[k]) begin
        phase_idx = phase_idx | PW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/johnson_checker.sv
// ============================================================================
// johnson_checker : Johnson-counter sequence monitor with lock, laps and errors
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_checker
  import johnson_checker_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LOCK_N = 4,
  parameter int LAP_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             count,
  output logic [phase_bits(WIDTH)-1:0] phase,
  output logic                         legal,
  output logic                         locked,
  output logic [LAP_W-1:0]             lap_count,
  output logic                         err,
  output logic                         err_sticky
);

  localparam int PW    = phase_bits(WIDTH);
  localparam int RUN_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
  localparam logic [PW-1:0]    LAST_PHASE = PW'(2 * WIDTH - 1);
  localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(LOCK_N - 1);

  state_t             r_state;
  logic [RUN_W-1:0]   r_run;
  logic [PW-1:0]      r_phase;
  logic               r_legal;
  logic               r_locked;
  logic [LAP_W-1:0]   r_lap;
  logic               r_err;
  logic               r_err_sticky;

  logic               w_legal;
  logic [PW-1:0]      w_idx;
  logic [PW-1:0]      w_next_phase;
  logic               w_adv;
  logic               w_hold;
  logic               w_wrap;

  johnson_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .count     (count),
    .is_legal  (w_legal),
    .phase_idx (w_idx)
  );

  // r_phase always holds the last legal phase, which is the successor reference.
  assign w_next_phase = (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
  assign w_adv        = w_legal && (w_idx == w_next_phase);
  assign w_hold       = w_legal && (w_idx == r_phase);
  assign w_wrap       = w_adv && (r_phase == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_run        <= '0;
      r_phase      <= '0;
      r_legal      <= 1'b0;
      r_locked     <= 1'b0;
      r_lap        <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_legal <= w_legal;
      if (w_legal) begin
        r_phase <= w_idx;
      end
      r_err <= 1'b0;

      case (r_state)
        SEARCH: begin
          if (w_legal) begin
            r_state <= ACQUIRE;
            r_run   <= '0;
          end
        end
        ACQUIRE: begin
          if (w_adv) begin
            if (r_run == RUN_LAST) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_run    <= '0;
              if (w_wrap) begin
                r_lap <= r_lap + LAP_W'(1);
              end
            end else begin
              r_run <= r_run + RUN_W'(1);
            end
          end else if (!w_hold) begin
            r_state <= SEARCH;
            r_run   <= '0;
          end
        end
        LOCKED: begin
          if (w_wrap) begin
            r_lap <= r_lap + LAP_W'(1);
          end else if (!(w_adv || w_hold)) begin
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
            r_locked     <= 1'b0;
            r_state      <= SEARCH;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
          r_run    <= '0;
        end
      endcase
    end
  end

  assign phase      = r_phase;
  assign legal      = r_legal;
  assign locked     = r_locked;
  assign lap_count  = r_lap;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_johnson_checker.sv
// ============================================================================
// tb_johnson_checker : directed self-checking bench for johnson_checker
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_johnson_checker;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic [3:0] phase;
  logic       legal;
  logic       locked;
  logic [1:0] lap_count;
  logic       err;
  logic       err_sticky;

  int n_assert;
  int n_fail;

  johnson_checker #(
    .WIDTH  (8),
    .LOCK_N (4),
    .LAP_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .phase      (phase),
    .legal      (legal),
    .locked     (locked),
    .lap_count  (lap_count),
    .err        (err),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Johnson word for phase k, built bit by bit.
  function automatic logic [7:0] jw(input int k);
    logic [7:0] w;
    for (int b = 0; b < 8; b++) begin
      w[b] = (k <= 8) ? (b < k) : (b >= k - 8);
    end
    return w;
  endfunction

  task automatic tick(input logic [7:0] w);
    count = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_phase, input logic e_legal,
                         input logic e_locked, input logic [1:0] e_lap, input logic e_err,
                         input logic e_sticky);
    chk({tag, ".phase"},      32'(phase),      32'(e_phase));
    chk({tag, ".legal"},      32'(legal),      32'(e_legal));
    chk({tag, ".locked"},     32'(locked),     32'(e_locked));
    chk({tag, ".lap_count"},  32'(lap_count),  32'(e_lap));
    chk({tag, ".err"},        32'(err),        32'(e_err));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(e_sticky));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    count    = 8'h00;

    // Reset for two cycles; the word present during reset is ignored.
    tick(jw(5));
    tick(jw(5));
    chk_all("reset", 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Clean run: phases 0..15 repeating for 40 cycles.
    for (int c = 1; c <= 40; c++) begin
      tick(jw((c - 1) % 16));
      chk_all($sformatf("clean%0d", c), 4'((c - 1) % 16), 1'b1, (c >= 5),
              (c >= 33) ? 2'd2 : (c >= 17) ? 2'd1 : 2'd0, 1'b0, 1'b0);
    end

    // Advance from phase 8 to phase 3, wrapping once more (lap 3).
    for (int k = 8; k <= 19; k++) begin
      tick(jw(k % 16));
      chk_all($sformatf("adv%0d", k), 4'(k % 16), 1'b1, 1'b1,
              (k >= 16) ? 2'd3 : 2'd2, 1'b0, 1'b0);
    end

    // Hold tolerance at phase 3, then resume with phase 4.
    for (int h = 0; h < 5; h++) begin
      tick(8'b0000_0111);
      chk_all($sformatf("hold%0d", h), 4'd3, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    end
    tick(8'b0000_1111);
    chk_all("resume", 4'd4, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);

    // Illegal word while locked.
    tick(8'b0000_0101);
    chk_all("illegal", 4'd4, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1);
    tick(jw(5));
    chk_all("search5", 4'd5, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    for (int k = 6; k <= 8; k++) begin
      tick(jw(k));
      chk_all($sformatf("acq%0d", k), 4'(k), 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    end
    tick(jw(9));
    chk_all("relock", 4'd9, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1);

    // Advance to phase 6; the wrap takes the 2-bit lap counter from 3 to 0.
    for (int k = 10; k <= 22; k++) begin
      tick(jw(k % 16));
      chk_all($sformatf("to6_%0d", k), 4'(k % 16), 1'b1, 1'b1,
              (k >= 16) ? 2'd0 : 2'd3, 1'b0, 1'b1);
    end

    // Skip from phase 6 to phase 8: legal word, but not a successor.
    tick(8'hFF);
    chk_all("skip", 4'd8, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    tick(jw(9));
    chk_all("skip_after", 4'd9, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

    // Reset, then an acquire that fails on an illegal word.
    reset = 1'b1;
    tick(jw(9));
    chk_all("reset2", 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      tick(jw(k));
      chk_all($sformatf("acqf%0d", k), 4'(k), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    end
    tick(8'b0010_0000);
    chk_all("acq_fail", 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    // Back in SEARCH: phase 3 restarts acquisition, so lock needs phase 7.
    for (int k = 3; k <= 6; k++) begin
      tick(jw(k));
      chk_all($sformatf("reacq%0d", k), 4'(k), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    end
    tick(jw(7));
    chk_all("reacq_lock", 4'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);

    // Four laps (0->1->2->3->0) and one more to leave lap_count at 1.
    for (int k = 8; k <= 87; k++) begin
      tick(jw(k % 16));
      chk_all($sformatf("lap_k%0d", k), 4'(k % 16), 1'b1, 1'b1,
              2'((k / 16) % 4), 1'b0, 1'b0);
    end

    // Set the sticky flag, then a one-cycle reset clears everything.
    tick(8'b1010_0101);
    chk_all("pre_rst_err", 4'd7, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    tick(jw(8));
    chk_all("pre_rst", 4'd8, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
    reset = 1'b1;
    tick(jw(9));
    chk_all("mid_reset", 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(jw(3));
    chk_all("post_reset", 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
